// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the ID/EX control bundle
// (reused by the EX/MEM and MEM/WB registers) and the ID/EX slot actions.
package pipe_pkg;

  localparam int WORD_W  = 16;
  localparam int REG_AW  = 2;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 16;

  localparam logic [ALUOP_W-1:0] ALU_NOP = '0;

  // Control bits that travel with an instruction down the pipe.
  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  // A dead slot: nothing writes, nothing touches memory, so forwarding
  // logic downstream can never match it.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    alu_op:     ALU_NOP
  };

  // What the ID/EX register does on the next rising edge.
  typedef enum logic [1:0] {
    SLOT_LOAD  = 2'd0,
    SLOT_STALL = 2'd1,
    SLOT_FLUSH = 2'd2
  } slot_action_e;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ID->EX boundary bundle. The ID side (master) supplies the decoded
// instruction and the flush request; the stage (slave) returns the
// registered EX slot, the stall request and the performance counters.
interface id_ex_hazard_stage_if #(
  parameter int WORD_W  = pipe_pkg::WORD_W,
  parameter int REG_AW  = pipe_pkg::REG_AW,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W,
  parameter int CNT_W   = pipe_pkg::CNT_W
);

  // ID-side instruction
  logic               id_valid;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic [WORD_W-1:0]  id_rs_data;
  logic [WORD_W-1:0]  id_rt_data;
  logic [WORD_W-1:0]  id_imm;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_mem_to_reg;
  logic               id_alu_src;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               ex_flush;

  // Stage outputs
  logic               stall_if_id;
  logic               ex_valid;
  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [REG_AW-1:0]  ex_rd;
  logic [WORD_W-1:0]  ex_rs_data;
  logic [WORD_W-1:0]  ex_rt_data;
  logic [WORD_W-1:0]  ex_imm;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_mem_to_reg;
  logic               ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, ex_flush,
    input  stall_if_id, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data,
           ex_rt_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_alu_op, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_reg_write, id_mem_read,
           id_mem_write, id_mem_to_reg, id_alu_src, id_alu_op, ex_flush,
    output stall_if_id, ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data,
           ex_rt_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_alu_src, ex_alu_op, stall_count, flush_count
  );

endinterface

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// Load-use hazard detection. Purely combinational: a load sitting in EX
// whose destination is read by the instruction in ID forces one bubble.
// Register 0 is an ordinary register here, so index 0 matches like any other.
module hazard_detect #(
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_flush,
  output logic              load_use,
  output logic              stall_if_id
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);

  assign load_use = ex_valid && ex_mem_read && ex_reg_write && id_valid
                    && (rs_hit || rt_hit);

  // A flush kills the ID instruction anyway, so holding IF/ID would be wrong.
  assign stall_if_id = load_use && !ex_flush;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump
// flush, and saturating stall/flush performance counters.
module id_ex_hazard_stage #(
  parameter int WORD_W = pipe_pkg::WORD_W,
  parameter int REG_AW = pipe_pkg::REG_AW,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input logic                clk,
  input logic                reset_n,
  id_ex_hazard_stage_if.slave bus
);

  import pipe_pkg::*;

  // Registered EX slot
  logic              ex_valid_q;
  id_ex_ctrl_t       ex_ctrl_q;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [WORD_W-1:0] ex_rs_data_q;
  logic [WORD_W-1:0] ex_rt_data_q;
  logic [WORD_W-1:0] ex_imm_q;

  // Next-state of the EX slot
  logic              nxt_valid;
  id_ex_ctrl_t       nxt_ctrl;
  logic [REG_AW-1:0] nxt_rs;
  logic [REG_AW-1:0] nxt_rt;
  logic [REG_AW-1:0] nxt_rd;
  logic [WORD_W-1:0] nxt_rs_data;
  logic [WORD_W-1:0] nxt_rt_data;
  logic [WORD_W-1:0] nxt_imm;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              load_use;
  logic              stall_if_id;
  id_ex_ctrl_t       id_ctrl;
  slot_action_e      action;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ex_ctrl_q.mem_read),
    .ex_reg_write (ex_ctrl_q.reg_write),
    .ex_rd        (ex_rd_q),
    .id_valid     (bus.id_valid),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rs   (bus.id_uses_rs),
    .id_uses_rt   (bus.id_uses_rt),
    .ex_flush     (bus.ex_flush),
    .load_use     (load_use),
    .stall_if_id  (stall_if_id)
  );

  // Pack ID control bits; an empty ID slot carries no side effects.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    id_ctrl = CTRL_BUBBLE;
    if (bus.id_valid) begin
      id_ctrl.reg_write  = bus.id_reg_write;
      id_ctrl.mem_read   = bus.id_mem_read;
      id_ctrl.mem_write  = bus.id_mem_write;
      id_ctrl.mem_to_reg = bus.id_mem_to_reg;
      id_ctrl.alu_src    = bus.id_alu_src;
      id_ctrl.alu_op     = bus.id_alu_op;
    end
  end

  // Choose the slot action: flush beats load-use, load-use beats load.
  always_comb begin
    action = SLOT_LOAD;
    if (bus.ex_flush) begin
      action = SLOT_FLUSH;
    end else if (load_use) begin
      action = SLOT_STALL;
    end
  end

  // Priority mux into the ID/EX register; stall and flush both insert a bubble.
  always_comb begin
    nxt_valid   = 1'b0;
    nxt_ctrl    = CTRL_BUBBLE;
    nxt_rs      = '0;
    nxt_rt      = '0;
    nxt_rd      = '0;
    nxt_rs_data = '0;
    nxt_rt_data = '0;
    nxt_imm     = '0;
    if (action == SLOT_LOAD) begin
      nxt_valid   = bus.id_valid;
      nxt_ctrl    = id_ctrl;
      nxt_rs      = bus.id_rs;
      nxt_rt      = bus.id_rt;
      nxt_rd      = bus.id_rd;
      nxt_rs_data = bus.id_rs_data;
      nxt_rt_data = bus.id_rt_data;
      nxt_imm     = bus.id_imm;
    end
  end

  // ID/EX pipeline register; reset leaves an empty slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= CTRL_BUBBLE;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
    end else begin
      ex_valid_q   <= nxt_valid;
      ex_ctrl_q    <= nxt_ctrl;
      ex_rs_q      <= nxt_rs;
      ex_rt_q      <= nxt_rt;
      ex_rd_q      <= nxt_rd;
      ex_rs_data_q <= nxt_rs_data;
      ex_rt_data_q <= nxt_rt_data;
      ex_imm_q     <= nxt_imm;
    end
  end

  // Saturating counters: load-use bubbles, and flushes that killed a real instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((action == SLOT_STALL) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if ((action == SLOT_FLUSH) && bus.id_valid && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.stall_if_id   = stall_if_id;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_rs         = ex_rs_q;
  assign bus.ex_rt         = ex_rt_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_rs_data    = ex_rs_data_q;
  assign bus.ex_rt_data    = ex_rt_data_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
  assign bus.stall_count   = stall_cnt_q;
  assign bus.flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Self-checking bench for id_ex_hazard_stage: directed scenarios with
// literal expectations, then randomized traffic against a behavioural
// model of the ID/EX slot and counters. Counters are narrowed to 8 bits
// so saturation is reachable in a short run.
module tb_id_ex_hazard_stage;

  localparam int TB_CNT_W = 8;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [1:0]  rd;
    logic        uses_rs;
    logic        uses_rt;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
  } instr_t;

  logic clk;
  logic reset_n;

  id_ex_hazard_stage_if #(.CNT_W(TB_CNT_W)) bus_if ();

  id_ex_hazard_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the EX slot must hold and what the counters must read.
  instr_t mdl;
  int     m_stall;
  int     m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                                input logic [1:0] rd, input logic urs, input logic urt,
                                input logic rw, input logic mr, input logic mw, input logic m2r,
                                input logic as, input logic [3:0] op, input logic [15:0] rsd,
                                input logic [15:0] rtd, input logic [15:0] imm);
    instr_t r;
    r.valid = v; r.rs = rs; r.rt = rt; r.rd = rd; r.uses_rs = urs; r.uses_rt = urt;
    r.reg_write = rw; r.mem_read = mr; r.mem_write = mw; r.mem_to_reg = m2r;
    r.alu_src = as; r.alu_op = op; r.rs_data = rsd; r.rt_data = rtd; r.imm = imm;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid      = ($urandom_range(0, 7) != 0);
    r.rs         = 2'($urandom);
    r.rt         = 2'($urandom);
    r.rd         = 2'($urandom);
    r.uses_rs    = 1'($urandom);
    r.uses_rt    = 1'($urandom);
    r.reg_write  = ($urandom_range(0, 3) != 0);
    r.mem_read   = ($urandom_range(0, 2) == 0);
    r.mem_write  = 1'($urandom);
    r.mem_to_reg = 1'($urandom);
    r.alu_src    = 1'($urandom);
    r.alu_op     = 4'($urandom);
    r.rs_data    = 16'($urandom);
    r.rt_data    = 16'($urandom);
    r.imm        = 16'($urandom);
    return r;
  endfunction

  // Does the instruction in ID read the destination of a load sitting in EX?
  function automatic bit hazard(input instr_t ex, input instr_t id);
    if (!(ex.valid && ex.mem_read && ex.reg_write && id.valid)) return 1'b0;
    return (id.uses_rs && id.rs == ex.rd) || (id.uses_rt && id.rt == ex.rd);
  endfunction

  task automatic apply(input instr_t i, input bit fl);
    bus_if.id_valid      = i.valid;
    bus_if.id_rs         = i.rs;
    bus_if.id_rt         = i.rt;
    bus_if.id_rd         = i.rd;
    bus_if.id_uses_rs    = i.uses_rs;
    bus_if.id_uses_rt    = i.uses_rt;
    bus_if.id_rs_data    = i.rs_data;
    bus_if.id_rt_data    = i.rt_data;
    bus_if.id_imm        = i.imm;
    bus_if.id_reg_write  = i.reg_write;
    bus_if.id_mem_read   = i.mem_read;
    bus_if.id_mem_write  = i.mem_write;
    bus_if.id_mem_to_reg = i.mem_to_reg;
    bus_if.id_alu_src    = i.alu_src;
    bus_if.id_alu_op     = i.alu_op;
    bus_if.ex_flush      = fl;
  endtask

  task automatic model_reset();
    mdl     = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // What one rising edge must do to the EX slot and counters.
  task automatic model_edge(input instr_t i, input bit fl);
    if (fl) begin
      if (i.valid && m_flush < CNT_MAX) m_flush++;
      mdl = '0;
    end else if (hazard(mdl, i)) begin
      if (m_stall < CNT_MAX) m_stall++;
      mdl = '0;
    end else begin
      mdl = i;
      if (!i.valid) begin
        mdl.reg_write = 0; mdl.mem_read = 0; mdl.mem_write = 0;
        mdl.mem_to_reg = 0; mdl.alu_src = 0; mdl.alu_op = '0;
      end
    end
  endtask

  // Compare every DUT output with the model for the currently applied ID inputs.
  task automatic compare_all(input instr_t i, input bit fl);
    check("stall_if_id",   32'(bus_if.stall_if_id),   32'(hazard(mdl, i) && !fl));
    check("ex_valid",      32'(bus_if.ex_valid),      32'(mdl.valid));
    check("ex_reg_write",  32'(bus_if.ex_reg_write),  32'(mdl.reg_write));
    check("ex_mem_read",   32'(bus_if.ex_mem_read),   32'(mdl.mem_read));
    check("ex_mem_write",  32'(bus_if.ex_mem_write),  32'(mdl.mem_write));
    check("ex_mem_to_reg", 32'(bus_if.ex_mem_to_reg), 32'(mdl.mem_to_reg));
    check("ex_alu_src",    32'(bus_if.ex_alu_src),    32'(mdl.alu_src));
    check("ex_alu_op",     32'(bus_if.ex_alu_op),     32'(mdl.alu_op));
    check("ex_rs",         32'(bus_if.ex_rs),         32'(mdl.rs));
    check("ex_rt",         32'(bus_if.ex_rt),         32'(mdl.rt));
    check("ex_rd",         32'(bus_if.ex_rd),         32'(mdl.rd));
    check("ex_rs_data",    32'(bus_if.ex_rs_data),    32'(mdl.rs_data));
    check("ex_rt_data",    32'(bus_if.ex_rt_data),    32'(mdl.rt_data));
    check("ex_imm",        32'(bus_if.ex_imm),        32'(mdl.imm));
    check("stall_count",   32'(bus_if.stall_count),   32'(m_stall));
    check("flush_count",   32'(bus_if.flush_count),   32'(m_flush));
  endtask

  // One cycle: drive inputs after the falling edge, compare, advance model, cross the rising edge.
  task automatic step(input instr_t i, input bit fl);
    apply(i, fl);
    #1;
    compare_all(i, fl);
    model_edge(i, fl);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sync_reset();
    apply('0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Assert reset between edges and confirm everything clears before the next rising edge.
  task automatic async_reset_check();
    #2 reset_n = 1'b0;
    #1;
    check("rst ex_valid",     32'(bus_if.ex_valid),     32'h0);
    check("rst ex_reg_write", 32'(bus_if.ex_reg_write), 32'h0);
    check("rst ex_mem_read",  32'(bus_if.ex_mem_read),  32'h0);
    check("rst ex_mem_write", 32'(bus_if.ex_mem_write), 32'h0);
    check("rst ex_mem_to_reg",32'(bus_if.ex_mem_to_reg),32'h0);
    check("rst ex_alu_src",   32'(bus_if.ex_alu_src),   32'h0);
    check("rst ex_alu_op",    32'(bus_if.ex_alu_op),    32'h0);
    check("rst ex_rs",        32'(bus_if.ex_rs),        32'h0);
    check("rst ex_rt",        32'(bus_if.ex_rt),        32'h0);
    check("rst ex_rd",        32'(bus_if.ex_rd),        32'h0);
    check("rst ex_rs_data",   32'(bus_if.ex_rs_data),   32'h0);
    check("rst ex_rt_data",   32'(bus_if.ex_rt_data),   32'h0);
    check("rst ex_imm",       32'(bus_if.ex_imm),       32'h0);
    check("rst stall_count",  32'(bus_if.stall_count),  32'h0);
    check("rst flush_count",  32'(bus_if.flush_count),  32'h0);
    check("rst stall_if_id",  32'(bus_if.stall_if_id),  32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  instr_t lw_r1, add_r1, add_r0, rt_unused, pass;
  instr_t cur;
  bit     fl;

  initial begin
    // LW r1,4(r2) ; ADD r2,r1,r3 ; ADD r2,r0,r3 ; instr with rt=1 but uses_rt=0
    lw_r1     = mk(1, 2'd2, 2'd0, 2'd1, 1, 0, 1, 1, 0, 1, 1, 4'h1, 16'h0100, 16'h0000, 16'h0004);
    add_r1    = mk(1, 2'd1, 2'd3, 2'd2, 1, 1, 1, 0, 0, 0, 0, 4'h2, 16'hAAAA, 16'h5555, 16'h0000);
    add_r0    = mk(1, 2'd0, 2'd3, 2'd2, 1, 1, 1, 0, 0, 0, 0, 4'h2, 16'h1111, 16'h2222, 16'h0000);
    rt_unused = mk(1, 2'd2, 2'd1, 2'd3, 1, 0, 1, 0, 0, 0, 1, 4'h3, 16'h3333, 16'h4444, 16'h0010);
    pass      = mk(1, 2'd1, 2'd2, 2'd3, 1, 0, 1, 0, 0, 0, 1, 4'h2, 16'h1234, 16'h0BAD, 16'h00FF);

    reset_n = 1'b0;
    apply('0, 1'b0);
    @(negedge clk);
    sync_reset();

    // Load-use: one stall cycle, a bubble, then the dependent instruction.
    step(lw_r1, 0);
    check("T2 ex_mem_read after LW", 32'(bus_if.ex_mem_read), 32'h1);
    apply(add_r1, 0);
    #1 check("T2 stall_if_id", 32'(bus_if.stall_if_id), 32'h1);
    step(add_r1, 0);
    check("T2 bubble ex_valid",     32'(bus_if.ex_valid),     32'h0);
    check("T2 bubble ex_reg_write", 32'(bus_if.ex_reg_write), 32'h0);
    check("T2 stall_count",         32'(bus_if.stall_count),  32'h1);
    #1 check("T2 no restall", 32'(bus_if.stall_if_id), 32'h0);
    step(add_r1, 0);
    check("T2 ADD ex_rd",    32'(bus_if.ex_rd),    32'h2);
    check("T2 ADD ex_valid", 32'(bus_if.ex_valid), 32'h1);

    // No false stall: r0 is a normal register but differs from r1; unused rt ignored.
    step(lw_r1, 0);
    apply(add_r0, 0);
    #1 check("T3 r0 stall_if_id", 32'(bus_if.stall_if_id), 32'h0);
    step(add_r0, 0);
    check("T3 r0 ex_rs_data", 32'(bus_if.ex_rs_data), 32'h1111);
    step(lw_r1, 0);
    apply(rt_unused, 0);
    #1 check("T3 rt unused stall_if_id", 32'(bus_if.stall_if_id), 32'h0);
    step(rt_unused, 0);
    check("T3 rt unused ex_rd", 32'(bus_if.ex_rd), 32'h3);

    // Flush beats stall.
    step(lw_r1, 0);
    apply(add_r1, 1);
    #1 check("T4 stall_if_id", 32'(bus_if.stall_if_id), 32'h0);
    step(add_r1, 1);
    check("T4 ex_valid",    32'(bus_if.ex_valid),    32'h0);
    check("T4 flush_count", 32'(bus_if.flush_count), 32'h1);
    check("T4 stall_count", 32'(bus_if.stall_count), 32'h1);

    // Passthrough of every field.
    step(pass, 0);
    check("T5 ex_rs_data", 32'(bus_if.ex_rs_data), 32'h1234);
    check("T5 ex_rt_data", 32'(bus_if.ex_rt_data), 32'h0BAD);
    check("T5 ex_imm",     32'(bus_if.ex_imm),     32'h00FF);
    check("T5 ex_alu_op",  32'(bus_if.ex_alu_op),  32'h2);
    check("T5 ex_alu_src", 32'(bus_if.ex_alu_src), 32'h1);
    check("T5 ex_rs",      32'(bus_if.ex_rs),      32'h1);

    // Randomized traffic; a stalled instruction is re-presented, as upstream would.
    cur = rand_instr();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        async_reset_check();
      end
      fl = ($urandom_range(0, 9) == 0);
      begin
        bit stalled;
        stalled = hazard(mdl, cur) && !fl;
        step(cur, fl);
        if (!stalled) cur = rand_instr();
      end
    end

    // Stall counter saturation.
    sync_reset();
    for (int n = 0; n < CNT_MAX; n++) begin
      step(lw_r1, 0);
      step(add_r1, 0);
    end
    check("T6 stall_count at max", 32'(bus_if.stall_count), 32'hFF);
    step(lw_r1, 0);
    step(add_r1, 0);
    check("T6 stall_count held", 32'(bus_if.stall_count), 32'hFF);

    // Flush counter saturation.
    for (int n = 0; n < CNT_MAX + 1; n++) begin
      step(lw_r1, 1);
    end
    check("T6 flush_count held", 32'(bus_if.flush_count), 32'hFF);
    step(pass, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
